// File: rtl/pwm_capture.sv
// Multi-channel PWM input capture: per-channel period and high time in clk_i cycles,
// read as a coherent pair, with sticky VALID/OVF status bits cleared by writing 1.
module pwm_capture #(
    parameter int CHANNEL = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        data_i,
    input  logic [31:0]        addr_i,
    input  logic               we_i,
    output logic [31:0]        data_o,
    input  logic [CHANNEL-1:0] pwm_i
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_RISE = 2'd1;
    localparam logic [1:0] MEASURE   = 2'd2;

    localparam logic [7:0] ADDR_EN = 8'h24;
    localparam logic [7:0] ADDR_ST = 8'h25;

    localparam logic [31:0] CNT_MAX  = 32'hFFFF_FFFF;
    localparam logic [31:0] CNT_NEAR = 32'hFFFF_FFFE;

    logic [7:0]         reg_addr;
    logic               en_wr;
    logic               st_wr;
    logic [CHANNEL-1:0] en_q;
    logic [CHANNEL-1:0] valid_q;
    logic [CHANNEL-1:0] ovf_q;
    logic [CHANNEL-1:0] valid_set;
    logic [CHANNEL-1:0] ovf_set;
    logic [CHANNEL-1:0] valid_clr;
    logic [CHANNEL-1:0] ovf_clr;
    logic [31:0]        status_w;
    logic [31:0]        period_w [CHANNEL];
    logic [31:0]        high_w   [CHANNEL];
    logic               unused_bits;

    assign reg_addr = addr_i[23:16];
    assign en_wr    = we_i && (reg_addr == ADDR_EN);
    assign st_wr    = we_i && (reg_addr == ADDR_ST);

    assign unused_bits = ^{addr_i[31:24], addr_i[15:0], data_i};

    assign valid_clr = st_wr ? data_i[CHANNEL-1:0] : '0;
    assign ovf_clr   = st_wr ? data_i[8 +: CHANNEL] : '0;

    assign status_w = 32'(valid_q) | (32'(ovf_q) << 8);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q <= '0;
        end else if (en_wr) begin
            en_q <= data_i[CHANNEL-1:0];
        end
    end

    // A hardware set in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            valid_q <= (valid_q & ~valid_clr) | valid_set;
            ovf_q   <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

    for (genvar i = 0; i < CHANNEL; i++) begin : g_ch
        logic [2:0]  sync_q;
        logic [1:0]  state_q;
        logic [31:0] cnt;
        logic [31:0] cnt_inc;
        logic [31:0] high_tmp;
        logic [31:0] period_q;
        logic [31:0] high_q;
        logic        rise;
        logic        fall;
        logic        measuring;

        // Two sync stages plus one history stage.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[1:0], pwm_i[i]};
            end
        end

        assign rise = sync_q[1] & ~sync_q[2];
        assign fall = ~sync_q[1] & sync_q[2];

        assign cnt_inc   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 32'd1;
        assign measuring = en_q[i] && (state_q == MEASURE);

        assign valid_set[i] = measuring && rise;
        assign ovf_set[i]   = measuring && !rise && (cnt == CNT_NEAR);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q  <= IDLE;
                cnt      <= '0;
                high_tmp <= '0;
                period_q <= '0;
                high_q   <= '0;
            end else if (!en_q[i]) begin
                state_q  <= IDLE;
                cnt      <= '0;
                high_tmp <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= WAIT_RISE;
                    end
                    WAIT_RISE: begin
                        if (rise) begin
                            cnt     <= 32'd1;
                            state_q <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_q <= cnt;
                            high_q   <= high_tmp;
                            cnt      <= 32'd1;
                        end else begin
                            cnt <= cnt_inc;
                            if (fall) begin
                                high_tmp <= cnt;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end

        assign period_w[i] = period_q;
        assign high_w[i]   = high_q;
    end

    always_comb begin
        data_o = '0;
        unique case (1'b1)
            (reg_addr == ADDR_EN): data_o = 32'(en_q);
            (reg_addr == ADDR_ST): data_o = status_w;
            default: begin
                for (int k = 0; k < CHANNEL; k++) begin
                    if (reg_addr == 8'(k)) begin
                        data_o = period_w[k];
                    end
                    if (reg_addr == 8'(16 + k)) begin
                        data_o = high_w[k];
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: cycle-counting waveform model feeds a per-channel
// queue of expected {period, high} pairs, drained whenever VALID shows up.
`timescale 1ns/1ps
module tb_pwm_capture;

    localparam int CH = 4;
    localparam logic [7:0] A_EN = 8'h24;
    localparam logic [7:0] A_ST = 8'h25;

    typedef struct {
        int unsigned per;
        int unsigned hi;
    } pair_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [31:0]   data_i;
    logic [31:0]   addr_i;
    logic          we_i;
    logic [31:0]   data_o;
    logic [CH-1:0] pwm_i;

    pair_t exp_q [CH][$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    bit    armed [CH];
    bit    tb_en [CH];
    int    last_rise [CH];
    int    last_fall [CH];

    pwm_capture #(.CHANNEL(CH)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .data_i (data_i),
        .addr_i (addr_i),
        .we_i   (we_i),
        .data_o (data_o),
        .pwm_i  (pwm_i)
    );

    always #10 clk_i = ~clk_i;

    always @(posedge clk_i) cyc++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     tag, got, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        addr_i = {8'h00, a, 16'h0000};
        #1;
        d = data_o;
    endtask

    task automatic expect_reg(input string tag,
                              input logic [7:0] a,
                              input logic [31:0] e);
        logic [31:0] d;
        @(negedge clk_i);
        rd(a, d);
        check(tag, d, e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk_i);
        #1;
        addr_i = {8'h00, a, 16'h0000};
        data_i = d;
        we_i   = 1'b1;
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
    endtask

    task automatic set_en(input logic [31:0] m);
        wr(A_EN, m);
        for (int c = 0; c < CH; c++) begin
            tb_en[c] = m[c];
            if (!m[c]) armed[c] = 1'b0;
        end
    endtask

    function automatic void clear_model();
        for (int c = 0; c < CH; c++) begin
            armed[c] = 1'b0;
            tb_en[c] = 1'b0;
            exp_q[c].delete();
        end
    endfunction

    function automatic void on_rise(input int c);
        pair_t e;
        if (armed[c]) begin
            e.per = cyc - last_rise[c];
            e.hi  = last_fall[c] - last_rise[c];
            exp_q[c].push_back(e);
        end
        armed[c]     = tb_en[c];
        last_rise[c] = cyc;
    endfunction

    task automatic wave(input int c, input int per,
                        input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i);
            #1;
            pwm_i[c] = 1'b1;
            on_rise(c);
            repeat (hi) @(posedge clk_i);
            #1;
            pwm_i[c] = 1'b0;
            last_fall[c] = cyc;
            repeat (per - hi - 1) @(posedge clk_i);
        end
    endtask

    // Coherent snapshot: STATUS and the pair are read in one low phase.
    task automatic sb_poll();
        logic [31:0] st;
        logic [31:0] p;
        logic [31:0] h;
        logic [CH-1:0] clr;
        pair_t e;
        @(negedge clk_i);
        rd(A_ST, st);
        clr = '0;
        for (int c = 0; c < CH; c++) begin
            if (st[c]) begin
                rd(8'(c), p);
                rd(8'(16 + c), h);
                clr[c] = 1'b1;
                check($sformatf("sb_avail_ch%0d", c),
                      32'(exp_q[c].size() != 0), 32'd1);
                if (exp_q[c].size() != 0) begin
                    e = exp_q[c].pop_front();
                    check($sformatf("sb_per_ch%0d", c), p, e.per);
                    check($sformatf("sb_hi_ch%0d", c), h, e.hi);
                end
            end
        end
        if (clr != '0) begin
            addr_i = {8'h00, A_ST, 16'h0000};
            data_i = 32'(clr);
            we_i   = 1'b1;
            @(posedge clk_i);
            #1;
            we_i = 1'b0;
        end
    endtask

    task automatic mon(input int n);
        repeat (n) sb_poll();
    endtask

    task automatic sb_empty();
        for (int c = 0; c < CH; c++) begin
            check($sformatf("sb_empty_ch%0d", c),
                  32'(exp_q[c].size()), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int r_cyc;
        int f_cyc;
        rst_i  = 1'b1;
        we_i   = 1'b0;
        data_i = '0;
        addr_i = '0;
        pwm_i  = '0;
        clear_model();
        repeat (3) @(posedge clk_i);
        expect_reg("rst_en", A_EN, 32'h0);
        expect_reg("rst_status", A_ST, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        expect_reg("rst_per0", 8'h00, 32'h0);
        expect_reg("rst_hi3", 8'h13, 32'h0);

        // Register map corners
        set_en(32'hFFFF_FFFF);
        expect_reg("en_mask", A_EN, 32'h0000_000F);
        wr(8'h00, 32'h1234);
        expect_reg("ro_per0", 8'h00, 32'h0);
        expect_reg("unmapped_26", 8'h26, 32'h0);
        expect_reg("unmapped_04", 8'h04, 32'h0);
        set_en(32'h1);
        repeat (5) @(posedge clk_i);

        // Single channel 100/30
        wave(0, 100, 30, 2);
        repeat (5) @(posedge clk_i);
        expect_reg("valid0", A_ST, 32'h1);
        sb_poll();
        fork
            wave(0, 100, 30, 4);
            mon(450);
        join
        sb_empty();
        expect_reg("per0_100", 8'h00, 32'd100);
        expect_reg("hi0_30", 8'h10, 32'd30);

        // Mid-stream change to 250/200
        fork
            begin
                wave(0, 100, 30, 3);
                wave(0, 250, 200, 3);
            end
            mon(1150);
        join
        sb_empty();
        expect_reg("per0_250", 8'h00, 32'd250);
        expect_reg("hi0_200", 8'h10, 32'd200);

        // Async reset in the middle of a measurement
        fork
            wave(0, 100, 30, 3);
            begin
                repeat (150) @(posedge clk_i);
                #7;
                rst_i = 1'b1;
                clear_model();
                rd(A_EN, d);
                check("arst_en", d, 32'h0);
                rd(A_ST, d);
                check("arst_status", d, 32'h0);
                rd(8'h00, d);
                check("arst_per0", d, 32'h0);
                rd(8'h10, d);
                check("arst_hi0", d, 32'h0);
                repeat (4) @(posedge clk_i);
                #3;
                rst_i = 1'b0;
            end
        join
        repeat (10) @(posedge clk_i);
        expect_reg("idle_status", A_ST, 32'h0);
        expect_reg("idle_per0", 8'h00, 32'h0);

        // W1C colliding with a VALID set
        set_en(32'h1);
        repeat (5) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b0;
        repeat (20) @(posedge clk_i);
        @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b1;
        r_cyc = cyc;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        addr_i = {8'h00, A_ST, 16'h0000};
        data_i = 32'h1;
        we_i   = 1'b1;
        @(posedge clk_i);
        #1;
        we_i = 1'b0;
        expect_reg("w1c_collide", A_ST, 32'h1);
        expect_reg("man_per0", 8'h00, 32'd26);
        expect_reg("man_hi0", 8'h10, 32'd5);
        @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b0;
        f_cyc = cyc;
        wr(A_ST, 32'h1);
        expect_reg("w1c_idle", A_ST, 32'h0);

        // Counter saturation
        @(negedge clk_i);
        force dut.g_ch[0].cnt = 32'hFFFF_FFF0;
        @(negedge clk_i);
        release dut.g_ch[0].cnt;
        expect_reg("pre_ovf", A_ST, 32'h0);
        repeat (30) @(posedge clk_i);
        expect_reg("ovf_set", A_ST, 32'h100);
        @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b1;
        repeat (5) @(posedge clk_i);
        expect_reg("ovf_per0", 8'h00, 32'hFFFF_FFFF);
        expect_reg("ovf_hi0", 8'h10, 32'(f_cyc - r_cyc));
        expect_reg("ovf_status", A_ST, 32'h101);
        wr(A_ST, 32'h100);
        expect_reg("ovf_w1c", A_ST, 32'h1);
        @(posedge clk_i);
        #1;
        pwm_i[0] = 1'b0;

        // Four channels, then ch2 disabled
        @(negedge clk_i);
        rst_i = 1'b1;
        clear_model();
        repeat (2) @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        set_en(32'hF);
        repeat (5) @(posedge clk_i);
        fork
            wave(0, 10, 5, 64);
            wave(1, 20, 10, 32);
            wave(2, 40, 20, 16);
            wave(3, 80, 40, 8);
            mon(700);
        join
        sb_empty();
        for (int c = 0; c < CH; c++) begin
            expect_reg($sformatf("mc_per%0d", c), 8'(c), 32'(10 << c));
            expect_reg($sformatf("mc_hi%0d", c), 8'(16 + c), 32'(5 << c));
        end
        set_en(32'hB);
        fork
            wave(0, 10, 5, 64);
            wave(1, 20, 10, 32);
            wave(2, 40, 20, 16);
            wave(3, 80, 40, 8);
            mon(700);
        join
        sb_empty();
        expect_reg("frz_en", A_EN, 32'hB);
        expect_reg("frz_per2", 8'h02, 32'd40);
        expect_reg("frz_hi2", 8'h12, 32'd20);
        expect_reg("live_per0", 8'h00, 32'd10);
        expect_reg("live_per3", 8'h03, 32'd80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
